// File: rtl/zorro_master_pkg.sv
// Shared types and constants for the Zorro III bus-master cycle sequencer.
package zorro_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_ADDR,
    ST_DATA,
    ST_TERM,
    ST_HOLD,
    ST_RELEASE
  } zmc_state_t;

  localparam logic [3:0] DS_IDLE = 4'hF;

  // Width of a counter that must hold 0..timeout_cycles inclusive.
  function automatic int ZMC_CNT_W(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/zorro_sync.sv
// Two-flop synchroniser for active-low Zorro inputs; resets to the inactive (1) level.
module zorro_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/zorro_master_cycle.sv
// Zorro III bus-master cycle sequencer: arbitration, FCS_n/DS_n strobing, termination.
// Optional DTACK timeout enabled by defining ZMC_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | bus not requested
// REQUEST    | SBR_n asserted, waiting for synced grant
// ADDR       | address driven for FCS_SETUP cycles
// DATA       | FCS_n and DS_n asserted, waiting for DTACK/BERR/timeout
// TERM       | strobes released, ACK pulse (ERR on failure)
// HOLD       | bus still owned; back-to-back if REQ and grant present
// RELEASE    | SBR_n/MASTER dropped
module zorro_master_cycle
  import zorro_master_pkg::*;
#(
  parameter int FCS_SETUP      = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [3:0]  REQ_BE,
  output logic        ACK,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        SBR_n,
  input  logic        SBG_n,
  output logic        MASTER,
  output logic        ADDR_OE,
  output logic        FCS_n,
  output logic [3:0]  DS_n,
  output logic        READ,
  output logic        DOE,
  input  logic [31:0] AD_IN,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  input  logic        BUS_RST
);

  localparam int SETUP_W = (FCS_SETUP > 1) ? $clog2(FCS_SETUP) : 1;
  localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(FCS_SETUP - 1);

  zmc_state_t state_q, state_d;
  logic [SETUP_W-1:0] setup_q, setup_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sbr_n_q, sbr_n_d;
  logic        master_q, master_d;
  logic        addr_oe_q, addr_oe_d;
  logic        fcs_n_q, fcs_n_d;
  logic [3:0]  ds_n_q, ds_n_d;
  logic        read_q, read_d;
  logic        doe_q, doe_d;

  logic sbg_s;
  logic dtack_s;
  logic berr_s;
  logic timeout_hit;
  logic pending;

  zorro_sync u_sync_sbg   (.clk_i(CLK), .rst_i(RESET), .d_i(SBG_n),   .q_o(sbg_s));
  zorro_sync u_sync_dtack (.clk_i(CLK), .rst_i(RESET), .d_i(DTACK_n), .q_o(dtack_s));
  zorro_sync u_sync_berr  (.clk_i(CLK), .rst_i(RESET), .d_i(BERR_n),  .q_o(berr_s));

`ifdef ZMC_TIMEOUT_EN
  localparam int CNT_W = ZMC_CNT_W(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_q, to_d;

  // Held at zero outside DATA so every DATA entry starts from a cleared count.
  always_comb begin
    to_d = '0;
    if (state_q == ST_DATA) begin
      to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) to_q <= '0;
    else       to_q <= to_d;
  end

  assign timeout_hit = (state_q == ST_DATA) && (to_d == TO_MAX);
`else
  logic unused_timeout;
  assign unused_timeout = 1'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // Address and write data reach the AD bus through external drivers gated by ADDR_OE/DOE.
  logic unused_fields;
  assign unused_fields = ^{REQ_ADDR, REQ_WDATA};

  assign pending = (state_q == ST_REQUEST) || (state_q == ST_ADDR) || (state_q == ST_DATA);

  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // ack_q blocks the request that is being acknowledged by an abort this cycle.
        if (REQ && !ack_q && sbg_s && !BUS_RST) state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (!sbg_s) begin
          state_d = ST_ADDR;
          setup_d = SETUP_LOAD;
        end
      end
      ST_ADDR: begin
        if (setup_q == '0) state_d = ST_DATA;
        else               setup_d = setup_q - 1'b1;
      end
      ST_DATA: begin
        if (!berr_s) begin
          state_d = ST_TERM;
          err_d   = 1'b1;
        end else if (!dtack_s) begin
          state_d = ST_TERM;
        end else if (timeout_hit) begin
          state_d = ST_TERM;
          err_d   = 1'b1;
        end
        if (state_d == ST_TERM) begin
          ack_d = 1'b1;
          if (!REQ_WRITE) rdata_d = AD_IN;
        end
      end
      ST_TERM: state_d = ST_HOLD;
      ST_HOLD: begin
        if (REQ && !sbg_s) begin
          state_d = ST_ADDR;
          setup_d = SETUP_LOAD;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (BUS_RST && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      ack_d   = pending;
      err_d   = pending;
      rdata_d = rdata_q;
    end

    // Outputs are decoded from the next state so they register together with it.
    sbr_n_d   = !((state_d == ST_REQUEST) || (state_d == ST_ADDR) || (state_d == ST_DATA) ||
                  (state_d == ST_TERM) || (state_d == ST_HOLD));
    master_d  = (state_d == ST_ADDR) || (state_d == ST_DATA) ||
                (state_d == ST_TERM) || (state_d == ST_HOLD);
    addr_oe_d = (state_d == ST_ADDR);
    fcs_n_d   = (state_d != ST_DATA);
    ds_n_d    = (state_d == ST_DATA) ? ~REQ_BE : DS_IDLE;
    doe_d     = (state_d == ST_DATA) && REQ_WRITE;
    read_d    = ((state_d == ST_ADDR) || (state_d == ST_DATA)) ? ~REQ_WRITE : 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      setup_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      sbr_n_q   <= 1'b1;
      master_q  <= 1'b0;
      addr_oe_q <= 1'b0;
      fcs_n_q   <= 1'b1;
      ds_n_q    <= DS_IDLE;
      read_q    <= 1'b1;
      doe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      setup_q   <= setup_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      sbr_n_q   <= sbr_n_d;
      master_q  <= master_d;
      addr_oe_q <= addr_oe_d;
      fcs_n_q   <= fcs_n_d;
      ds_n_q    <= ds_n_d;
      read_q    <= read_d;
      doe_q     <= doe_d;
    end
  end

  assign ACK     = ack_q;
  assign ERR     = err_q;
  assign RDATA   = rdata_q;
  assign SBR_n   = sbr_n_q;
  assign MASTER  = master_q;
  assign ADDR_OE = addr_oe_q;
  assign FCS_n   = fcs_n_q;
  assign DS_n    = ds_n_q;
  assign READ    = read_q;
  assign DOE     = doe_q;

endmodule
